// File: rtl/md_unit_if.sv
// Bus between the E stage / hazard unit and the multiply-divide unit.
// Member names carry i_/o_ prefixes as seen from the md_unit (slave) side.
interface md_unit_if;
   logic        i_start;
   logic [2:0]  i_op;
   logic [31:0] i_a;
   logic [31:0] i_b;
   logic        i_d_md_use;
   logic        o_busy;
   logic        o_stall_md;
   logic [31:0] o_hi;
   logic [31:0] o_lo;

   modport master (
      output i_start, i_op, i_a, i_b, i_d_md_use,
      input  o_busy, o_stall_md, o_hi, o_lo
   );

   modport slave (
      input  i_start, i_op, i_a, i_b, i_d_md_use,
      output o_busy, o_stall_md, o_hi, o_lo
   );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS-style HI/LO multiply/divide unit (IDLE/RUN FSM with down-counter).
// Optional macro MDU_MADD_EN builds the MADD/MADDU accumulate path for ops 6/7.
module md_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic      i_clk,
   input logic      i_reset,
   md_unit_if.slave md
);
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic [0:0]  r_state;
   logic [3:0]  r_cnt;
   logic [2:0]  r_op;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_md_class;
   logic        w_long_op;
   logic        w_start_div;
   logic        w_busy;
   logic        w_b_zero;
   logic        w_div_ovf;
   logic        w_write_res;
   logic [31:0] w_b_safe;
   logic [63:0] w_prod_s;
   logic [63:0] w_prod_u;
   logic [31:0] w_sq;
   logic [31:0] w_sr;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [63:0] w_result;

   assign w_md_class  = (md.i_op != OP_MTHI) && (md.i_op != OP_MTLO);
`ifdef MDU_MADD_EN
   assign w_long_op   = w_md_class;
`else
   assign w_long_op   = ~md.i_op[2];
`endif
   assign w_start_div = (md.i_op == OP_DIV) || (md.i_op == OP_DIVU);
   assign w_busy      = (r_state == S_RUN);

   assign md.o_busy     = w_busy;
   assign md.o_stall_md = md.i_d_md_use & (w_busy | (md.i_start & w_md_class));
   assign md.o_hi       = r_hi;
   assign md.o_lo       = r_lo;

   assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
   assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

   // Dividing by 1 on overflow yields exactly the required 0x80000000 / 0 pair.
   assign w_b_zero  = (r_b == 32'd0);
   assign w_div_ovf = (r_op == OP_DIV) && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
   assign w_b_safe  = (w_b_zero || w_div_ovf) ? 32'd1 : r_b;
   assign w_sq      = $signed(r_a) / $signed(w_b_safe);
   assign w_sr      = $signed(r_a) % $signed(w_b_safe);
   assign w_uq      = r_a / w_b_safe;
   assign w_ur      = r_a % w_b_safe;

   assign w_write_res = !(((r_op == OP_DIV) || (r_op == OP_DIVU)) && w_b_zero);

   always_comb begin
      w_result = {r_hi, r_lo};
      case (r_op)
         OP_MULT:  w_result = w_prod_s;
         OP_MULTU: w_result = w_prod_u;
         OP_DIV:   w_result = {w_sr, w_sq};
         OP_DIVU:  w_result = {w_ur, w_uq};
`ifdef MDU_MADD_EN
         OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
         OP_MADDU: w_result = {r_hi, r_lo} + w_prod_u;
`endif
         default:  w_result = {r_hi, r_lo};
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_op    <= 3'd0;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (md.i_start) begin
                  if (w_long_op) begin
                     r_a     <= md.i_a;
                     r_b     <= md.i_b;
                     r_op    <= md.i_op;
                     r_cnt   <= w_start_div ? DIV_LOAD : MULT_LOAD;
                     r_state <= S_RUN;
                  end else if (md.i_op == OP_MTHI) begin
                     r_hi <= md.i_a;
                  end else if (md.i_op == OP_MTLO) begin
                     r_lo <= md.i_a;
                  end
               end
            end
            S_RUN: begin
               // start is ignored here; the hazard unit never issues into a busy unit.
               if (r_cnt == 4'd1) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
                  if (w_write_res) begin
                     r_hi <= w_result[63:32];
                     r_lo <= w_result[31:0];
                  end
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed vector table plus hand-written corner sequences.
module tb_md_unit;
   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MADD  = 3'd6;
   localparam logic [2:0] OP_MADDU = 3'd7;
`ifdef MDU_MADD_EN
   localparam bit MADD = 1'b1;
`else
   localparam bit MADD = 1'b0;
`endif

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pre_hi;
      logic [31:0] pre_lo;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
      int          exp_busy;
   } vec_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   vec_t vecs[14];

   md_unit_if u_if ();

   md_unit #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) u_dut (
      .i_clk   (clk),
      .i_reset (reset),
      .md      (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      u_if.i_start = 1'b1;
      u_if.i_op    = op;
      u_if.i_a     = a;
      u_if.i_b     = b;
      @(negedge clk);
      u_if.i_start = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (u_if.o_busy && n < 20) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_errors = 0;
      reset = 1'b0;
      u_if.i_start    = 1'b0;
      u_if.i_op       = 3'd0;
      u_if.i_a        = 32'd0;
      u_if.i_b        = 32'd0;
      u_if.i_d_md_use = 1'b1;

      //          op        a             b             pre_hi      pre_lo        exp_hi                      exp_lo                      busy
      vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'h3,        32'h0,      32'h0,        32'hFFFFFFFF,               32'hFFFFFFFA,               5};
      vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,      32'h0,        32'hFFFFFFFE,               32'h00000001,               5};
      vecs[2]  = '{OP_MULT,  32'h7,        32'hFFFFFFFD, 32'h0,      32'h0,        32'hFFFFFFFF,               32'hFFFFFFEB,               5};
      vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'h0,      32'h0,        32'hFFFFFFFF,               32'hFFFFFFFD,               10};
      vecs[4]  = '{OP_DIVU,  32'h7,        32'h2,        32'h0,      32'h0,        32'h1,                      32'h3,                      10};
      vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h5,      32'h6,        32'h0,                      32'h80000000,               10};
      vecs[6]  = '{OP_DIVU,  32'h5,        32'h0,        32'h11,     32'h22,       32'h11,                     32'h22,                     10};
      vecs[7]  = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h0,      32'h0,        32'h1,                      32'hFFFFFFFD,               10};
      vecs[8]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h10,       32'h0,      32'h0,        32'hF,                      32'h0FFFFFFF,               10};
      vecs[9]  = '{OP_MADDU, 32'h1,        32'h1,        32'h0,      32'hFFFFFFFF, MADD ? 32'h1 : 32'h0,       MADD ? 32'h0 : 32'hFFFFFFFF, MADD ? 5 : 0};
      vecs[10] = '{OP_MADD,  32'hFFFFFFFF, 32'h2,        32'h0,      32'h5,        32'h0,                      MADD ? 32'h3 : 32'h5,       MADD ? 5 : 0};
      vecs[11] = '{OP_MTHI,  32'hDEADBEEF, 32'h0,        32'h1,      32'h2,        32'hDEADBEEF,               32'h2,                      0};
      vecs[12] = '{OP_MTLO,  32'h12345678, 32'h0,        32'h1,      32'h2,        32'h1,                      32'h12345678,               0};
      vecs[13] = '{OP_DIV,   32'h0,        32'h0,        32'hAB,     32'hCD,       32'hAB,                     32'hCD,                     10};

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(u_if.o_busy), 32'd0);
      check("reset_hi", u_if.o_hi, 32'd0);
      check("reset_lo", u_if.o_lo, 32'd0);
      check("reset_stall", 32'(u_if.o_stall_md), 32'd0);
      reset = 1'b1;
      u_if.i_d_md_use = 1'b0;

      for (int i = 0; i < 14; i++) begin
         issue(OP_MTHI, vecs[i].pre_hi, 32'd0);
         issue(OP_MTLO, vecs[i].pre_lo, 32'd0);
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         count_busy(n);
         check($sformatf("v%0d_busy", i), 32'(n), 32'(vecs[i].exp_busy));
         check($sformatf("v%0d_hi", i), u_if.o_hi, vecs[i].exp_hi);
         check($sformatf("v%0d_lo", i), u_if.o_lo, vecs[i].exp_lo);
      end

      // stall_md across a MULTU with d_md_use held high
      u_if.i_d_md_use = 1'b1;
      @(negedge clk);
      check("stall_idle", 32'(u_if.o_stall_md), 32'd0);
      u_if.i_start = 1'b1;
      u_if.i_op    = OP_MULTU;
      u_if.i_a     = 32'd3;
      u_if.i_b     = 32'd4;
      #1;
      check("stall_start", 32'(u_if.o_stall_md), 32'd1);
      check("stall_start_busy", 32'(u_if.o_busy), 32'd0);
      @(negedge clk);
      u_if.i_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall_busy%0d", k), 32'(u_if.o_busy), 32'd1);
         check($sformatf("stall_run%0d", k), 32'(u_if.o_stall_md), 32'd1);
         @(negedge clk);
      end
      check("stall_end_busy", 32'(u_if.o_busy), 32'd0);
      check("stall_end", 32'(u_if.o_stall_md), 32'd0);
      check("stall_lo", u_if.o_lo, 32'd12);
      u_if.i_start = 1'b1;
      u_if.i_op    = OP_MTHI;
      #1;
      check("stall_mthi", 32'(u_if.o_stall_md), 32'd0);
      @(negedge clk);
      u_if.i_start = 1'b0;
      u_if.i_d_md_use = 1'b0;

      // Reset in the third busy cycle of a DIV aborts it
      issue(OP_MTHI, 32'hAA, 32'd0);
      issue(OP_MTLO, 32'hBB, 32'd0);
      issue(OP_DIV, 32'd100, 32'd7);
      check("abort_busy1", 32'(u_if.o_busy), 32'd1);
      repeat (2) @(negedge clk);
      check("abort_busy3", 32'(u_if.o_busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("abort_busy", 32'(u_if.o_busy), 32'd0);
      check("abort_hi", u_if.o_hi, 32'd0);
      check("abort_lo", u_if.o_lo, 32'd0);
      repeat (15) @(negedge clk);
      check("abort_late_busy", 32'(u_if.o_busy), 32'd0);
      check("abort_late_hi", u_if.o_hi, 32'd0);
      check("abort_late_lo", u_if.o_lo, 32'd0);

      // start while busy is ignored (MTHI and DIV during a MULT)
      issue(OP_MULT, 32'd2, 32'd3);
      n = 0;
      while (u_if.o_busy && n < 20) begin
         n++;
         u_if.i_start = 1'b0;
         if (n == 2) begin
            u_if.i_start = 1'b1;
            u_if.i_op    = OP_MTHI;
            u_if.i_a     = 32'hFFFF;
         end else if (n == 3) begin
            u_if.i_start = 1'b1;
            u_if.i_op    = OP_DIV;
            u_if.i_a     = 32'd9;
            u_if.i_b     = 32'd2;
         end
         @(negedge clk);
      end
      u_if.i_start = 1'b0;
      check("ignore_busy", 32'(n), 32'd5);
      check("ignore_hi", u_if.o_hi, 32'd0);
      check("ignore_lo", u_if.o_lo, 32'd6);
      repeat (3) @(negedge clk);
      check("ignore_idle", 32'(u_if.o_busy), 32'd0);

      // start coincident with reset is discarded
      @(negedge clk);
      reset = 1'b0;
      u_if.i_start = 1'b1;
      u_if.i_op    = OP_MULT;
      u_if.i_a     = 32'd5;
      u_if.i_b     = 32'd5;
      @(negedge clk);
      reset = 1'b1;
      u_if.i_start = 1'b0;
      check("rst_start_busy", 32'(u_if.o_busy), 32'd0);
      repeat (8) @(negedge clk);
      check("rst_start_hi", u_if.o_hi, 32'd0);
      check("rst_start_lo", u_if.o_lo, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter: MULT_CYCLES, default 5, busy cycles for MULT/MULTU/MADD/MADDU (legal range 1..15).
REQ-002 Parameter: DIV_CYCLES, default 10, busy cycles for DIV/DIVU (legal range 1..15).
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port: start  in  1  E-stage MD instruction valid this cycle; one-cycle pulse per instruction.
REQ-006 Port: op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU.
REQ-007 Port: a  in  32  rs operand (forwarded value).
REQ-008 Port: b  in  32  rt operand (forwarded value).
REQ-009 Port: d_md_use  in  1  D-stage instruction is an MD-class instruction (mult/div/mthi/mtlo/mfhi/mflo/madd/maddu).
REQ-010 Port: busy  out  1  computation in progress.
REQ-011 Port: stall_md  out  1  stall request to the hazard unit, ORed with the data-hazard stall.
REQ-012 Port: hi  out  32  HI register value.
REQ-013 Port: lo  out  32  LO register value.

Function
REQ-014 The block SHALL be an FSM with states IDLE and RUN plus a 4-bit down-counter cnt.
REQ-015 In IDLE, start with op 0,1,2,3,6,7 SHALL latch a, b and op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN next cycle.
REQ-016 busy SHALL be 1 exactly for MULT_CYCLES (or DIV_CYCLES) consecutive cycles, starting the cycle after start.
REQ-017 In RUN, cnt SHALL decrement each cycle; at cnt==1 the next edge SHALL write hi/lo and return to IDLE, with busy 0 in the same cycle the new hi/lo become visible.
REQ-018 MULT: {hi,lo} = signed a * signed b (64-bit); MULTU: unsigned product.
REQ-019 DIV: lo = signed quotient truncated toward zero, hi = remainder with the sign of the dividend; DIVU: unsigned quotient/remainder.
REQ-020 DIV with a=0x80000000, b=0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000.
REQ-021 Divide by zero (b==0) SHALL still run DIV_CYCLES busy cycles and SHALL leave hi/lo unchanged.
REQ-022 MTHI/MTLO with start in IDLE SHALL write a to hi/lo at the next edge, with busy staying 0.
REQ-023 start while busy SHALL be ignored (no state change); the hazard unit guarantees this does not occur, and the bench checks it is harmless.
REQ-024 stall_md SHALL be combinational: d_md_use & (busy | (start & op is 0,1,2,3,6,7)).
REQ-025 op values 6/7 without MDU_MADD_EN SHALL be no-ops, starting no busy period.

Reset
REQ-026 With reset==0 at a rising edge: state IDLE, cnt 0, busy 0, hi 0, lo 0, latched operands 0.
REQ-027 Reset asserted mid-RUN SHALL abort the operation; no hi/lo write SHALL occur afterwards.
REQ-028 start coincident with reset SHALL be discarded.

Configuration
REQ-029 Macro MDU_MADD_EN defined: op 6 {hi,lo} += signed a*b, op 7 {hi,lo} += unsigned a*b (64-bit wrap), both using MULT_CYCLES timing.
REQ-030 Macro MDU_MADD_EN undefined: no accumulator logic is built, and ops 6/7 follow REQ-025.

Verification
REQ-031 MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1.
REQ-033 DIVU a=5, b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, then hi=0x11, lo=0x22.
REQ-034 MULTU start with d_md_use=1 held -> stall_md=1 in the start cycle and all 5 busy cycles, then 0 the cycle busy falls.
REQ-035 reset=0 in the 3rd busy cycle of DIV -> next cycle busy=0, hi=0, lo=0, and no later write occurs.
REQ-036 MDU_MADD_EN defined, hi=0, lo=0xFFFFFFFF, MADDU a=1, b=1 -> hi=1, lo=0; undefined -> hi/lo unchanged and busy never rises.
